// File: rtl/e203_exu_wbck_arb_pkg.sv
// Shared constants and types for the EXU writeback arbiter.
// The width constants mirror E203_XLEN / E203_RFIDX_WIDTH of the core-wide defines.
package e203_exu_wbck_arb_pkg;

    localparam int E203_XLEN        = 32;
    localparam int E203_RFIDX_WIDTH = 5;

    typedef enum logic [1:0] {
        WBCK_GNT_NONE  = 2'd0,
        WBCK_GNT_ALU   = 2'd1,
        WBCK_GNT_LONGP = 2'd2
    } wbck_gnt_e;

endpackage

// File: rtl/e203_exu_wbck_lfifo.sv
// Small synchronous FIFO buffering long-pipe writeback entries {rdidx, wdat}.
// Only pointers and occupancy are reset; the storage array is left uninitialised.
module e203_exu_wbck_lfifo #(
    parameter int DW    = 37,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [DW-1:0]    wdat,
    output logic [DW-1:0]    rdat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DW-1:0]    mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    // Storage write; no reset so the array maps onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdat;
        end
    end

    // Write pointer; DEPTH is a power of two so wrap is natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
        end else if (push) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= PTR_W'(0);
        end else if (pop) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_r <= rd_ptr_r;
        end
    end

    // Occupancy; simultaneous push and pop leaves it unchanged, even when full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CNT_W'(0);
        end else begin
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rdat  = mem_r[rd_ptr_r];
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));
    assign count = count_r;

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Writeback arbiter merging single-cycle ALU results and buffered long-pipe
// results onto the single integer regfile write port, with starvation bounding.
module e203_exu_wbck_arb
    import e203_exu_wbck_arb_pkg::*;
#(
    parameter int XLEN        = E203_XLEN,
    parameter int RFIDX_W     = E203_RFIDX_WIDTH,
    parameter int LFIFO_DEPTH = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           alu_wbck_i_valid,
    output logic                           alu_wbck_i_ready,
    input  logic [XLEN-1:0]                alu_wbck_i_wdat,
    input  logic [RFIDX_W-1:0]             alu_wbck_i_rdidx,
    input  logic                           longp_wbck_i_valid,
    output logic                           longp_wbck_i_ready,
    input  logic [XLEN-1:0]                longp_wbck_i_wdat,
    input  logic [RFIDX_W-1:0]             longp_wbck_i_rdidx,
    output logic                           rf_wbck_o_ena,
    output logic [XLEN-1:0]                rf_wbck_o_wdat,
    output logic [RFIDX_W-1:0]             rf_wbck_o_rdidx,
    output logic [$clog2(LFIFO_DEPTH):0]   lfifo_cnt,
    output logic                           wbck_busy
);

    localparam int CNT_W    = $clog2(LFIFO_DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int ENT_W    = RFIDX_W + XLEN;
    localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

    logic                fifo_push_s;
    logic                fifo_pop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [ENT_W-1:0]    fifo_head_s;
    logic [CNT_W-1:0]    fifo_cnt_s;
    logic [STARVE_W-1:0] starve_cnt_r;
    wbck_gnt_e           gnt_s;
    logic [XLEN-1:0]     win_wdat_s;
    logic [RFIDX_W-1:0]  win_rdidx_s;

    e203_exu_wbck_lfifo #(
        .DW    (ENT_W),
        .DEPTH (LFIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_lfifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .wdat  ({longp_wbck_i_rdidx, longp_wbck_i_wdat}),
        .rdat  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_cnt_s)
    );

    // Grant: the FIFO head is forced when starved or full, otherwise it only fills idle ALU slots.
    always_comb begin
        gnt_s = WBCK_GNT_NONE;
        if (!fifo_empty_s &&
            ((starve_cnt_r == STARVE_TOP) || fifo_full_s || !alu_wbck_i_valid)) begin
            gnt_s = WBCK_GNT_LONGP;
        end else if (alu_wbck_i_valid) begin
            gnt_s = WBCK_GNT_ALU;
        end else begin
            gnt_s = WBCK_GNT_NONE;
        end
    end

    // Winner data mux; with no winner the ALU bus is passed through so nothing is X when valid.
    always_comb begin
        win_wdat_s  = alu_wbck_i_wdat;
        win_rdidx_s = alu_wbck_i_rdidx;
        case (gnt_s)
            WBCK_GNT_LONGP: begin
                win_rdidx_s = fifo_head_s[ENT_W-1:XLEN];
                win_wdat_s  = fifo_head_s[XLEN-1:0];
            end
            WBCK_GNT_ALU: begin
                win_rdidx_s = alu_wbck_i_rdidx;
                win_wdat_s  = alu_wbck_i_wdat;
            end
            default: begin
                win_rdidx_s = alu_wbck_i_rdidx;
                win_wdat_s  = alu_wbck_i_wdat;
            end
        endcase
    end

    assign fifo_pop_s         = (gnt_s == WBCK_GNT_LONGP);
    assign longp_wbck_i_ready = !fifo_full_s || fifo_pop_s;
    assign fifo_push_s        = longp_wbck_i_valid && longp_wbck_i_ready;
    assign alu_wbck_i_ready   = !fifo_pop_s;

    // x0 writes complete their handshake but never reach the regfile.
    assign rf_wbck_o_ena   = (gnt_s != WBCK_GNT_NONE) && (win_rdidx_s != {RFIDX_W{1'b0}});
    assign rf_wbck_o_wdat  = win_wdat_s;
    assign rf_wbck_o_rdidx = win_rdidx_s;
    assign lfifo_cnt       = fifo_cnt_s;
    assign wbck_busy       = !fifo_empty_s || alu_wbck_i_valid;

    // Consecutive ALU wins against a waiting head entry, saturating at STARVE_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= STARVE_W'(0);
        end else if (fifo_empty_s || fifo_pop_s) begin
            starve_cnt_r <= STARVE_W'(0);
        end else if ((gnt_s == WBCK_GNT_ALU) && (starve_cnt_r != STARVE_TOP)) begin
            starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Self-checking bench for e203_exu_wbck_arb: directed scenarios plus randomized
// traffic against a queue-based reference model of the arbitration rules.
module tb_e203_exu_wbck_arb;

    localparam int XLEN  = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid;
    logic            alu_ready;
    logic [XLEN-1:0] alu_wdat;
    logic [RW-1:0]   alu_rdidx;
    logic            lp_valid;
    logic            lp_ready;
    logic [XLEN-1:0] lp_wdat;
    logic [RW-1:0]   lp_rdidx;
    logic            ena;
    logic [XLEN-1:0] wdat;
    logic [RW-1:0]   rdidx;
    logic [CNT_W-1:0] cnt;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [RW-1:0]   idx;
        logic [XLEN-1:0] dat;
    } ent_t;

    ent_t mq[$];
    int   mstarve = 0;

    e203_exu_wbck_arb #(
        .XLEN        (XLEN),
        .RFIDX_W     (RW),
        .LFIFO_DEPTH (DEPTH),
        .STARVE_MAX  (SMAX)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .alu_wbck_i_valid   (alu_valid),
        .alu_wbck_i_ready   (alu_ready),
        .alu_wbck_i_wdat    (alu_wdat),
        .alu_wbck_i_rdidx   (alu_rdidx),
        .longp_wbck_i_valid (lp_valid),
        .longp_wbck_i_ready (lp_ready),
        .longp_wbck_i_wdat  (lp_wdat),
        .longp_wbck_i_rdidx (lp_rdidx),
        .rf_wbck_o_ena      (ena),
        .rf_wbck_o_wdat     (wdat),
        .rf_wbck_o_rdidx    (rdidx),
        .lfifo_cnt          (cnt),
        .wbck_busy          (busy)
    );

    always #5 clk = ~clk;

    // Reference model: advance one clock using the inputs presented this cycle.
    task automatic model_step();
        bit   had, full, lwin, awin;
        ent_t tmp;
        if (!rst_n) begin
            mq.delete();
            mstarve = 0;
        end else begin
            had  = (mq.size() > 0);
            full = (mq.size() == DEPTH);
            lwin = had && (mstarve == SMAX || full || !alu_valid);
            awin = alu_valid && !lwin;
            if (lwin) tmp = mq.pop_front();
            if (lp_valid && (!full || lwin)) mq.push_back({lp_rdidx, lp_wdat});
            if (!had || lwin) mstarve = 0;
            else if (awin && mstarve < SMAX) mstarve = mstarve + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_wdat = 32'h0; alu_rdidx = 5'd0;
        lp_valid  = 1'b0; lp_wdat  = 32'h0; lp_rdidx  = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        n_tests++; if (ena !== 1'b0) begin n_fail++; $display("FAIL rst_ena got %b exp 0", ena); end
        n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_alu_ready got %b exp 1", alu_ready); end
        n_tests++; if (lp_ready !== 1'b1) begin n_fail++; $display("FAIL rst_lp_ready got %b exp 1", lp_ready); end
        n_tests++; if (cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL rst_cnt got %0d exp 0", cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_tests++; if (ena !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle ena %b busy %b exp 0 0", ena, busy); end
        tick();
    endtask

    task automatic test_alu_alone();
        alu_valid = 1'b1; alu_rdidx = 5'd5; alu_wdat = 32'h0000_1234;
        #1;
        n_tests++; if (ena !== 1'b1 || rdidx !== 5'd5 || wdat !== 32'h1234)
            begin n_fail++; $display("FAIL alu_write ena %b idx %0d dat %h exp 1 5 1234", ena, rdidx, wdat); end
        n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready got %b exp 1", alu_ready); end
        tick();
        idle_inputs();
    endtask

    task automatic test_longp_alone();
        lp_valid = 1'b1; lp_rdidx = 5'd7; lp_wdat = 32'h0000_DEAD;
        #1;
        n_tests++; if (lp_ready !== 1'b1 || ena !== 1'b0)
            begin n_fail++; $display("FAIL lp_push_cycle ready %b ena %b exp 1 0", lp_ready, ena); end
        tick();
        idle_inputs();
        #1;
        n_tests++; if (cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL lp_cnt1 got %0d exp 1", cnt); end
        n_tests++; if (ena !== 1'b1 || rdidx !== 5'd7 || wdat !== 32'hDEAD)
            begin n_fail++; $display("FAIL lp_write ena %b idx %0d dat %h exp 1 7 dead", ena, rdidx, wdat); end
        tick();
        n_tests++; if (cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL lp_cnt0 got %0d exp 0", cnt); end
    endtask

    task automatic test_starvation();
        logic [RW-1:0] ai;
        alu_valid = 1'b1; alu_rdidx = 5'd1; alu_wdat = 32'h1;
        lp_valid = 1'b1; lp_rdidx = 5'd9; lp_wdat = 32'h0000_BEEF;
        tick();
        lp_valid = 1'b0;
        for (int c = 0; c < SMAX; c++) begin
            ai = RW'($urandom_range(1, 31));
            alu_rdidx = ai; alu_wdat = $urandom;
            #1;
            n_tests++; if (ena !== 1'b1 || rdidx !== ai || alu_ready !== 1'b1)
                begin n_fail++; $display("FAIL starve_alu_win%0d ena %b idx %0d rdy %b exp 1 %0d 1", c, ena, rdidx, alu_ready, ai); end
            tick();
        end
        #1;
        n_tests++; if (ena !== 1'b1 || rdidx !== 5'd9 || wdat !== 32'hBEEF || alu_ready !== 1'b0)
            begin n_fail++; $display("FAIL starve_forced ena %b idx %0d dat %h rdy %b exp 1 9 beef 0", ena, rdidx, wdat, alu_ready); end
        tick();
        #1;
        n_tests++; if (alu_ready !== 1'b1 || cnt !== CNT_W'(0) || rdidx !== alu_rdidx)
            begin n_fail++; $display("FAIL starve_resume rdy %b cnt %0d exp 1 0", alu_ready, cnt); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_full();
        alu_valid = 1'b1; alu_rdidx = 5'd3; alu_wdat = 32'h3;
        lp_valid = 1'b1; lp_rdidx = 5'd10; lp_wdat = 32'hA0;
        tick();
        lp_rdidx = 5'd11; lp_wdat = 32'hA1;
        #1;
        n_tests++; if (cnt !== CNT_W'(1) || alu_ready !== 1'b1 || lp_ready !== 1'b1)
            begin n_fail++; $display("FAIL full_fill cnt %0d rdy %b lrdy %b exp 1 1 1", cnt, alu_ready, lp_ready); end
        tick();
        lp_rdidx = 5'd12; lp_wdat = 32'hA2;
        #1;
        n_tests++; if (cnt !== CNT_W'(2) || alu_ready !== 1'b0 || lp_ready !== 1'b1 || rdidx !== 5'd10 || wdat !== 32'hA0)
            begin n_fail++; $display("FAIL full_forced cnt %0d rdy %b lrdy %b idx %0d exp 2 0 1 10", cnt, alu_ready, lp_ready, rdidx); end
        tick();
        lp_valid = 1'b0;
        #1;
        n_tests++; if (cnt !== CNT_W'(2) || rdidx !== 5'd11 || wdat !== 32'hA1)
            begin n_fail++; $display("FAIL full_pushpop cnt %0d idx %0d exp 2 11", cnt, rdidx); end
        tick();
        alu_valid = 1'b0;
        tick(); tick();
        n_tests++; if (cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL full_drain cnt %0d exp 0", cnt); end
        idle_inputs();
    endtask

    task automatic test_x0();
        alu_valid = 1'b1; alu_rdidx = 5'd0; alu_wdat = 32'hFFFF_FFFF;
        #1;
        n_tests++; if (alu_ready !== 1'b1 || ena !== 1'b0)
            begin n_fail++; $display("FAIL x0_alu rdy %b ena %b exp 1 0", alu_ready, ena); end
        tick();
        idle_inputs();
        lp_valid = 1'b1; lp_rdidx = 5'd0; lp_wdat = 32'h5555;
        tick();
        idle_inputs();
        #1;
        n_tests++; if (cnt !== CNT_W'(1) || alu_ready !== 1'b0 || ena !== 1'b0)
            begin n_fail++; $display("FAIL x0_lp cnt %0d pop %b ena %b exp 1 0 0", cnt, alu_ready, ena); end
        tick();
        n_tests++; if (cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL x0_lp_pop cnt %0d exp 0", cnt); end
    endtask

    task automatic test_async_reset();
        alu_valid = 1'b1; alu_rdidx = 5'd4; alu_wdat = 32'h4;
        lp_valid = 1'b1; lp_rdidx = 5'd20; lp_wdat = 32'hC0;
        tick();
        lp_rdidx = 5'd21; lp_wdat = 32'hC1;
        tick();
        idle_inputs();
        #1;
        n_tests++; if (cnt !== CNT_W'(2)) begin n_fail++; $display("FAIL arst_pre cnt %0d exp 2", cnt); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (cnt !== CNT_W'(0) || ena !== 1'b0 || alu_ready !== 1'b1 || lp_ready !== 1'b1)
            begin n_fail++; $display("FAIL arst_now cnt %0d ena %b rdy %b lrdy %b exp 0 0 1 1", cnt, ena, alu_ready, lp_ready); end
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++; if (ena !== 1'b0 || cnt !== CNT_W'(0))
                begin n_fail++; $display("FAIL arst_after%0d ena %b cnt %0d exp 0 0", c, ena, cnt); end
            tick();
        end
    endtask

    task automatic test_random();
        bit            had, full, lwin, awin, eena;
        logic [RW-1:0] eidx;
        logic [XLEN-1:0] edat;
        for (int c = 0; c < 400; c++) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rdidx = RW'($urandom_range(0, 31));
            alu_wdat  = $urandom;
            lp_valid  = ($urandom_range(0, 2) != 0);
            lp_rdidx  = RW'($urandom_range(0, 31));
            lp_wdat   = $urandom;
            #1;
            had  = (mq.size() > 0);
            full = (mq.size() == DEPTH);
            lwin = had && (mstarve == SMAX || full || !alu_valid);
            awin = alu_valid && !lwin;
            eidx = lwin ? mq[0].idx : alu_rdidx;
            edat = lwin ? mq[0].dat : alu_wdat;
            eena = (lwin || awin) && (eidx != 5'd0);
            n_tests++; if (ena !== eena)
                begin n_fail++; $display("FAIL rnd_ena c%0d got %b exp %b", c, ena, eena); end
            if (lwin || awin) begin
                n_tests++; if (rdidx !== eidx || wdat !== edat)
                    begin n_fail++; $display("FAIL rnd_data c%0d got %0d/%h exp %0d/%h", c, rdidx, wdat, eidx, edat); end
            end
            n_tests++; if (alu_ready !== !lwin || lp_ready !== (!full || lwin))
                begin n_fail++; $display("FAIL rnd_ready c%0d got %b%b exp %b%b", c, alu_ready, lp_ready, !lwin, (!full || lwin)); end
            n_tests++; if (cnt !== CNT_W'(mq.size()) || busy !== (had || alu_valid))
                begin n_fail++; $display("FAIL rnd_cnt c%0d got %0d/%b exp %0d/%b", c, cnt, busy, mq.size(), (had || alu_valid)); end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_alu_alone();
        test_longp_alone();
        test_starvation();
        test_full();
        test_x0();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
